mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- MEM pipeline stage. Sits between the EX/MEM register and the mem_wb writeback register.
- Executes loads and stores against the data memory over a req/gnt/rvalid handshake.
- Formats load data: byte-lane select plus sign/zero extension.
- Forwards rd data, rd address, rd enable and PC into mem_wb, and raises a stall request to the pipeline controller while a memory access is outstanding.

Parameters:
- XLEN, 64, register/data width
- PC_W, 64, PC width
- TIMEOUT_CYC, 255, max cycles waiting for gnt/rvalid before the access is abandoned

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ex_valid  in  1  EX/MEM holds a valid instruction this cycle
- ex_pc_i  in  PC_W  instruction PC
- ex_rd_addr  in  5  destination register
- ex_rd_ena  in  1  destination write enable
- ex_alu_res  in  XLEN  ALU result / effective address
- ex_store_data  in  XLEN  rs2 value for stores
- ex_mem_op  in  4  0 NONE,1 LB,2 LH,3 LW,4 LD,5 LBU,6 LHU,7 LWU,8 SB,9 SH,10 SW,11 SD, 12-15 treated as NONE
- stall_ctrl  in  5  pipeline stall vector; bit 3 = hold MEM
- dmem_req  out  1  request valid
- dmem_we  out  1  1 = store
- dmem_addr  out  XLEN  8-byte-aligned address
- dmem_wdata  out  XLEN  lane-shifted store data
- dmem_wstrb  out  8  byte strobes
- dmem_gnt  in  1  request accepted
- dmem_rvalid  in  1  response (load data or store ack)
- dmem_rdata  in  XLEN  load data, full doubleword
- mem_stall_req  out  1  to pipeline controller
- mem_rd_data  out  XLEN  to mem_wb
- mem_rd_addr  out  5  to mem_wb
- mem_rd_ena  out  1  to mem_wb
- mem_pc_o  out  PC_W  to mem_wb; 0 = bubble
- mem_err  out  1  one-cycle pulse on timeout (and on misalign, see Optional Feature)

Behaviour:
- Reset: state IDLE; all registered outputs 0 (mem_rd_*, mem_pc_o, dmem_*, mem_err); timeout counter 0.
- FSM has four states: IDLE, REQ, WAIT, RESP.
- IDLE:
  - If stall_ctrl[3]=1, hold all outputs.
  - Else if ex_valid and op is NONE: register rd data = ex_alu_res, rd addr, rd ena and pc. One-cycle latency.
  - Else if ex_valid and op is a memory op: latch op, address, data and pc; go to REQ. mem_rd_ena and mem_pc_o go to 0 (bubble).
  - Else output a bubble: rd_ena=0, pc=0.
- REQ:
  - dmem_req=1; addr/we/wdata/wstrb held stable until gnt.
  - dmem_gnt=1 -> WAIT. The gnt cycle deasserts req next cycle.
- WAIT:
  - dmem_rvalid=1 -> RESP, capture formatted data.
  - If gnt and rvalid arrive in the same cycle while in REQ, go directly to RESP.
- RESP:
  - Present the result for exactly one cycle: rd_ena = latched rd_ena for loads, 0 for stores; pc = latched pc. Then return to IDLE.
  - If stall_ctrl[3]=1, hold in RESP.
- mem_stall_req is combinational. It is 1 when state is REQ or WAIT, and also in IDLE when a memory op is being accepted. It is 0 in RESP.
- Lane rules:
  - off = addr[2:0]; dmem_addr = {addr[XLEN-1:3], 3'b0}.
  - wstrb = (1/3/F/FF) << off; wdata = store_data << 8*off.
  - Load data = rdata >> 8*off, then truncate to the op size and sign/zero-extend.
- Timeout: counter runs in REQ and WAIT. At TIMEOUT_CYC: pulse mem_err, emit a bubble, return to IDLE.
- Reset mid-operation: state returns to IDLE immediately. A late rvalid arriving in IDLE is ignored.
- Misaligned access when the macro is absent: uses the aligned-down doubleword; bytes beyond the doubleword are dropped.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- Defined: a misaligned access (H with off[0]≠0, W with off[1:0]≠0, D with off≠0) issues no bus request. It pulses mem_err, emits a bubble (rd_ena=0, pc=0) and does not stall.
- Undefined: behaviour as above; mem_err pulses on timeout only.

Decomposition:
- Shared defines: mem_op encodings, FSM state encodings, XLEN/PC widths, the ZEROWORD constant, the STOP/NOSTOP constants.
- Sub-module: mem_load_fmt. Purely combinational; inputs rdata, off, op; output extended data. Used only for load formatting.

Test Plan:
- ALU op passthrough: ex_mem_op=0, alu_res=0x1234, rd=5, pc=0x80000000 -> next cycle mem_rd_data=0x1234, addr=5, ena=1, pc=0x80000000; stall_req never 1.
- LB sign: addr=0x80001003, rdata=0x00000000_80FF0000 (byte 3 = 0x80) -> mem_rd_data=0xFFFFFFFFFFFFFF80; with LBU -> 0x80.
- SH: addr=0x...6, data=0xABCD -> wstrb=0xC0, wdata=0xABCD000000000000, mem_rd_ena=0 in RESP.
- Gnt delayed 3 cycles, rvalid 2 cycles after gnt -> req held 4 cycles, stall_req high until RESP, one result cycle.
- No gnt for TIMEOUT_CYC cycles -> mem_err one-cycle pulse, bubble, back to IDLE; rst asserted while in WAIT -> all outputs 0 next cycle.
- With MEM_MISALIGN_TRAP_EN defined: LW at off=2 -> no dmem_req, mem_err pulse, bubble.

Source files
------------

// File: rtl/mem_access_stage_pkg.sv
// rtl/mem_access_stage_pkg.sv - shared encodings, widths and op-decode helpers for the MEM stage
package mem_access_stage_pkg;

  localparam int DEF_XLEN = 64;
  localparam int DEF_PC_W = 64;
  localparam logic [63:0] ZEROWORD = 64'h0;
  localparam logic STOP = 1'b1;
  localparam logic NOSTOP = 1'b0;

  typedef enum logic [3:0] {
    MOP_NONE = 4'd0,
    MOP_LB   = 4'd1,
    MOP_LH   = 4'd2,
    MOP_LW   = 4'd3,
    MOP_LD   = 4'd4,
    MOP_LBU  = 4'd5,
    MOP_LHU  = 4'd6,
    MOP_LWU  = 4'd7,
    MOP_SB   = 4'd8,
    MOP_SH   = 4'd9,
    MOP_SW   = 4'd10,
    MOP_SD   = 4'd11
  } mem_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  function automatic logic op_is_load(input logic [3:0] op);
    return (op >= MOP_LB) && (op <= MOP_LWU);
  endfunction

  function automatic logic op_is_store(input logic [3:0] op);
    return (op >= MOP_SB) && (op <= MOP_SD);
  endfunction

  // log2 of the access size in bytes
  function automatic logic [1:0] op_size(input logic [3:0] op);
    case (op)
      MOP_LH, MOP_LHU, MOP_SH: return 2'd1;
      MOP_LW, MOP_LWU, MOP_SW: return 2'd2;
      MOP_LD, MOP_SD:          return 2'd3;
      default:                 return 2'd0;
    endcase
  endfunction

  function automatic logic [7:0] op_strb(input logic [3:0] op);
    case (op_size(op))
      2'd1:    return 8'h03;
      2'd2:    return 8'h0F;
      2'd3:    return 8'hFF;
      default: return 8'h01;
    endcase
  endfunction

  function automatic logic op_misaligned(input logic [3:0] op, input logic [2:0] off);
    case (op_size(op))
      2'd1:    return off[0];
      2'd2:    return |off[1:0];
      2'd3:    return |off;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_fmt.sv
// rtl/mem_load_fmt.sv - load data lane select and sign/zero extension
module mem_load_fmt
  import mem_access_stage_pkg::*;
#(
  parameter int XLEN = DEF_XLEN
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [2:0]      off,
  input  logic [3:0]      op,
  output logic [XLEN-1:0] data
);

  logic [XLEN-1:0] sh;

  always_comb begin
    sh = rdata >> {off, 3'b000};
    case (op)
      MOP_LB:  data = {{(XLEN-8){sh[7]}}, sh[7:0]};
      MOP_LBU: data = {{(XLEN-8){1'b0}}, sh[7:0]};
      MOP_LH:  data = {{(XLEN-16){sh[15]}}, sh[15:0]};
      MOP_LHU: data = {{(XLEN-16){1'b0}}, sh[15:0]};
      MOP_LW:  data = {{(XLEN-32){sh[31]}}, sh[31:0]};
      MOP_LWU: data = {{(XLEN-32){1'b0}}, sh[31:0]};
      default: data = sh;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM pipeline stage: dmem req/gnt/rvalid access, load formatting, mem_wb forwarding
// Optional misaligned-access trap: define MEM_MISALIGN_TRAP_EN.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int XLEN        = DEF_XLEN,
  parameter int PC_W        = DEF_PC_W,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  input  logic [PC_W-1:0] ex_pc_i,
  input  logic [4:0]      ex_rd_addr,
  input  logic            ex_rd_ena,
  input  logic [XLEN-1:0] ex_alu_res,
  input  logic [XLEN-1:0] ex_store_data,
  input  logic [3:0]      ex_mem_op,
  input  logic [4:0]      stall_ctrl,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [7:0]      dmem_wstrb,
  input  logic            dmem_gnt,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            mem_stall_req,
  output logic [XLEN-1:0] mem_rd_data,
  output logic [4:0]      mem_rd_addr,
  output logic            mem_rd_ena,
  output logic [PC_W-1:0] mem_pc_o,
  output logic            mem_err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_e          state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [3:0]      op_q, op_n;
  logic [2:0]      off_q, off_n;
  logic [4:0]      lat_rd_addr, lat_rd_addr_n;
  logic            lat_rd_ena, lat_rd_ena_n;
  logic [PC_W-1:0] lat_pc, lat_pc_n;
  logic            req_n, we_n, rd_ena_n, err_n;
  logic [XLEN-1:0] addr_n, wdata_n, rd_data_n, load_data;
  logic [7:0]      wstrb_n;
  logic [4:0]      rd_addr_n;
  logic [PC_W-1:0] pc_n;
  logic            hold, is_mem_op, ex_mem, misal, acc_mem, done, tmo;
  logic [2:0]      ex_off;
  logic            unused_stall_bits;

  assign unused_stall_bits = ^{stall_ctrl[4], stall_ctrl[2:0]};
  assign hold      = stall_ctrl[3];
  assign ex_off    = ex_alu_res[2:0];
  assign is_mem_op = op_is_load(ex_mem_op) || op_is_store(ex_mem_op);
  assign ex_mem    = ex_valid && is_mem_op;
`ifdef MEM_MISALIGN_TRAP_EN
  assign misal = op_misaligned(ex_mem_op, ex_off);
`else
  assign misal = 1'b0;
`endif
  assign acc_mem = (state == ST_IDLE) && !hold && ex_mem && !misal;
  assign mem_stall_req = ((state == ST_REQ) || (state == ST_WAIT) || acc_mem) ? STOP : NOSTOP;

  mem_load_fmt #(.XLEN(XLEN)) u_load_fmt (
    .rdata (dmem_rdata),
    .off   (off_q),
    .op    (op_q),
    .data  (load_data)
  );

  always_comb begin
    state_n = state;
    cnt_n = cnt;
    op_n = op_q;
    off_n = off_q;
    lat_rd_addr_n = lat_rd_addr;
    lat_rd_ena_n = lat_rd_ena;
    lat_pc_n = lat_pc;
    req_n = dmem_req;
    we_n = dmem_we;
    addr_n = dmem_addr;
    wdata_n = dmem_wdata;
    wstrb_n = dmem_wstrb;
    rd_data_n = mem_rd_data;
    rd_addr_n = mem_rd_addr;
    rd_ena_n = mem_rd_ena;
    pc_n = mem_pc_o;
    err_n = 1'b0;
    done = 1'b0;
    tmo = 1'b0;
    case (state)
      ST_IDLE: if (!hold) begin
        if (ex_valid && !is_mem_op) begin
          rd_data_n = ex_alu_res;
          rd_addr_n = ex_rd_addr;
          rd_ena_n = ex_rd_ena;
          pc_n = ex_pc_i;
        end else if (ex_mem && misal) begin
          rd_ena_n = 1'b0;
          pc_n = '0;
          err_n = 1'b1;
        end else if (ex_mem) begin
          op_n = ex_mem_op;
          off_n = ex_off;
          lat_rd_addr_n = ex_rd_addr;
          lat_rd_ena_n = ex_rd_ena;
          lat_pc_n = ex_pc_i;
          req_n = 1'b1;
          we_n = op_is_store(ex_mem_op);
          addr_n = {ex_alu_res[XLEN-1:3], 3'b000};
          wstrb_n = op_is_store(ex_mem_op) ? (op_strb(ex_mem_op) << ex_off) : 8'h00;
          wdata_n = op_is_store(ex_mem_op) ? (ex_store_data << {ex_off, 3'b000}) : XLEN'(ZEROWORD);
          rd_ena_n = 1'b0;
          pc_n = '0;
          cnt_n = '0;
          state_n = ST_REQ;
        end else begin
          rd_ena_n = 1'b0;
          pc_n = '0;
        end
      end
      ST_REQ: begin
        if (dmem_gnt) begin
          req_n = 1'b0;
          state_n = ST_WAIT;
          done = dmem_rvalid;
        end else begin
          tmo = (cnt >= TO_LAST);
        end
        cnt_n = cnt + 1'b1;
      end
      ST_WAIT: begin
        done = dmem_rvalid;
        tmo = !dmem_rvalid && (cnt >= TO_LAST);
        cnt_n = cnt + 1'b1;
      end
      ST_RESP: if (!hold) begin
        state_n = ST_IDLE;
        rd_ena_n = 1'b0;
        pc_n = '0;
      end
      default: state_n = ST_IDLE;
    endcase
    // completion and abandonment override whatever the state branch chose
    if (done) begin
      state_n = ST_RESP;
      rd_data_n = op_is_load(op_q) ? load_data : XLEN'(ZEROWORD);
      rd_addr_n = lat_rd_addr;
      rd_ena_n = op_is_load(op_q) && lat_rd_ena;
      pc_n = lat_pc;
    end
    if (tmo) begin
      state_n = ST_IDLE;
      req_n = 1'b0;
      rd_ena_n = 1'b0;
      pc_n = '0;
      err_n = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt <= '0;
      op_q <= '0;
      off_q <= '0;
      lat_rd_addr <= '0;
      lat_rd_ena <= 1'b0;
      lat_pc <= '0;
      dmem_req <= 1'b0;
      dmem_we <= 1'b0;
      dmem_addr <= '0;
      dmem_wdata <= '0;
      dmem_wstrb <= '0;
      mem_rd_data <= '0;
      mem_rd_addr <= '0;
      mem_rd_ena <= 1'b0;
      mem_pc_o <= '0;
      mem_err <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      op_q <= op_n;
      off_q <= off_n;
      lat_rd_addr <= lat_rd_addr_n;
      lat_rd_ena <= lat_rd_ena_n;
      lat_pc <= lat_pc_n;
      dmem_req <= req_n;
      dmem_we <= we_n;
      dmem_addr <= addr_n;
      dmem_wdata <= wdata_n;
      dmem_wstrb <= wstrb_n;
      mem_rd_data <= rd_data_n;
      mem_rd_addr <= rd_addr_n;
      mem_rd_ena <= rd_ena_n;
      mem_pc_o <= pc_n;
      mem_err <= err_n;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - scoreboard testbench for mem_access_stage
module tb_mem_access_stage;

  localparam int XLEN = 64;
  localparam int PC_W = 64;
  localparam int TMO  = 255;

  logic            clk = 1'b0;
  logic            rst;
  logic            ex_valid;
  logic [PC_W-1:0] ex_pc_i;
  logic [4:0]      ex_rd_addr;
  logic            ex_rd_ena;
  logic [XLEN-1:0] ex_alu_res;
  logic [XLEN-1:0] ex_store_data;
  logic [3:0]      ex_mem_op;
  logic [4:0]      stall_ctrl;
  logic            dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [XLEN-1:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [7:0]      dmem_wstrb;
  logic            mem_stall_req, mem_rd_ena, mem_err;
  logic [XLEN-1:0] mem_rd_data;
  logic [4:0]      mem_rd_addr;
  logic [PC_W-1:0] mem_pc_o;

  always #5 clk = ~clk;

  mem_access_stage #(.XLEN(XLEN), .PC_W(PC_W), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_pc_i(ex_pc_i), .ex_rd_addr(ex_rd_addr),
    .ex_rd_ena(ex_rd_ena), .ex_alu_res(ex_alu_res), .ex_store_data(ex_store_data),
    .ex_mem_op(ex_mem_op), .stall_ctrl(stall_ctrl), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .mem_stall_req(mem_stall_req),
    .mem_rd_data(mem_rd_data), .mem_rd_addr(mem_rd_addr), .mem_rd_ena(mem_rd_ena),
    .mem_pc_o(mem_pc_o), .mem_err(mem_err)
  );

  typedef struct {
    logic [63:0] data;
    bit          chk_data;
    logic [4:0]  addr;
    logic        ena;
    logic [63:0] pc;
  } res_t;

  res_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;
  bit   sb_on = 1'b1;
  bit   got_res = 1'b0;

  function automatic int op_bytes(input logic [3:0] op);
    case (op)
      4'd1, 4'd5, 4'd8:  return 1;
      4'd2, 4'd6, 4'd9:  return 2;
      4'd3, 4'd7, 4'd10: return 4;
      default:           return 8;
    endcase
  endfunction

  function automatic logic [63:0] exp_load(input logic [3:0] op, input logic [63:0] rd, input logic [2:0] off);
    int n;
    int idx;
    logic [63:0] v;
    n = op_bytes(op);
    v = '0;
    for (int i = 0; i < n; i++) begin
      idx = int'(off) + i;
      if (idx < 8) v[8*i +: 8] = rd[8*idx +: 8];
    end
    if ((op == 4'd1 || op == 4'd2 || op == 4'd3) && v[8*n-1])
      for (int i = n; i < 8; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  function automatic logic [7:0] exp_strb(input logic [3:0] op, input logic [2:0] off);
    logic [7:0] s;
    int idx;
    s = '0;
    for (int i = 0; i < op_bytes(op); i++) begin
      idx = int'(off) + i;
      if (idx < 8) s[idx] = 1'b1;
    end
    return s;
  endfunction

  function automatic logic [63:0] exp_wdata(input logic [3:0] op, input logic [63:0] sd, input logic [2:0] off);
    logic [63:0] w;
    int idx;
    w = '0;
    for (int i = 0; i < op_bytes(op); i++) begin
      idx = int'(off) + i;
      if (idx < 8) w[8*idx +: 8] = sd[8*i +: 8];
    end
    return w;
  endfunction

  // advance one cycle, sample at the falling edge and drain one scoreboard entry per result cycle
  task automatic tick();
    res_t e;
    @(posedge clk);
    @(negedge clk);
    got_res = 1'b0;
    if (sb_on && mem_pc_o != '0) begin
      got_res = 1'b1;
      n_vec++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL sb_unexpected: got pc=%h data=%h, scoreboard empty", mem_pc_o, mem_rd_data);
      end else begin
        e = sb.pop_front();
        if (mem_rd_addr !== e.addr || mem_rd_ena !== e.ena || mem_pc_o !== e.pc ||
            (e.chk_data && mem_rd_data !== e.data)) begin
          n_bad++;
          $display("FAIL sb_result: got data=%h addr=%0d ena=%b pc=%h, want data=%h addr=%0d ena=%b pc=%h",
                   mem_rd_data, mem_rd_addr, mem_rd_ena, mem_pc_o, e.data, e.addr, e.ena, e.pc);
        end
      end
    end
  endtask

  task automatic drive_idle();
    ex_valid = 1'b0;
    ex_mem_op = 4'd0;
    ex_alu_res = '0;
    ex_store_data = '0;
    ex_rd_addr = '0;
    ex_rd_ena = 1'b0;
    ex_pc_i = '0;
  endtask

  task automatic do_mem(input logic [3:0] op, input logic [63:0] addr, input logic [63:0] sdata,
                        input logic [63:0] rdata, input logic [63:0] exp_data,
                        input int gnt_dly, input int rv_dly, input logic [4:0] rd, input logic [63:0] pc,
                        input bit expect_res, input bit hold_resp,
                        output int req_cyc, output int stall_cyc, output bit saw_err,
                        output logic [63:0] cap_addr, output bit cap_we,
                        output logic [7:0] cap_strb, output logic [63:0] cap_wdata);
    res_t e;
    int gt;
    bit store;
    store = (op >= 4'd8);
    e.data = exp_data;
    e.chk_data = !store;
    e.addr = rd;
    e.ena = !store;
    e.pc = pc;
    ex_valid = 1'b1;
    ex_mem_op = op;
    ex_alu_res = addr;
    ex_store_data = sdata;
    ex_rd_addr = rd;
    ex_rd_ena = 1'b1;
    ex_pc_i = pc;
    #1;
    n_vec++;
    if (mem_stall_req !== 1'b1) begin
      n_bad++;
      $display("FAIL accept_stall: got %b want 1", mem_stall_req);
    end
    if (expect_res) sb.push_back(e);
    tick();
    drive_idle();
    req_cyc = 0;
    stall_cyc = 0;
    saw_err = 1'b0;
    gt = -1;
    cap_addr = '0;
    cap_we = 1'b0;
    cap_strb = '0;
    cap_wdata = '0;
    got_res = 1'b0;
    for (int t = 0; t < 600; t++) begin
      if (dmem_req) req_cyc++;
      if (mem_stall_req) stall_cyc++;
      dmem_gnt = (gt < 0) && dmem_req && (t == gnt_dly);
      if (dmem_gnt) begin
        gt = t;
        cap_addr = dmem_addr;
        cap_we = dmem_we;
        cap_strb = dmem_wstrb;
        cap_wdata = dmem_wdata;
      end
      dmem_rvalid = (gt >= 0) && (t == gt + rv_dly);
      dmem_rdata = dmem_rvalid ? rdata : {$urandom, $urandom};
      tick();
      dmem_gnt = 1'b0;
      dmem_rvalid = 1'b0;
      if (mem_err) begin
        saw_err = 1'b1;
        break;
      end
      if (got_res) break;
    end
    n_vec++;
    if (expect_res && !got_res) begin
      n_bad++;
      $display("FAIL handshake_done: no result within bound (err=%b)", saw_err);
    end
    if (got_res) begin
      n_vec++;
      if (mem_stall_req !== 1'b0) begin
        n_bad++;
        $display("FAIL resp_stall: got %b want 0", mem_stall_req);
      end
      if (hold_resp) begin
        sb_on = 1'b0;
        stall_ctrl = 5'b01000;
        tick();
        n_vec++;
        if (mem_pc_o !== pc || mem_rd_ena !== !store) begin
          n_bad++;
          $display("FAIL resp_hold: got pc=%h ena=%b want pc=%h ena=%b", mem_pc_o, mem_rd_ena, pc, !store);
        end
        stall_ctrl = 5'b00000;
        sb_on = 1'b1;
      end
      tick();
      n_vec++;
      if (mem_pc_o !== '0 || mem_rd_ena !== 1'b0) begin
        n_bad++;
        $display("FAIL one_result: got pc=%h ena=%b want pc=0 ena=0", mem_pc_o, mem_rd_ena);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    stall_ctrl = '0;
    dmem_gnt = 1'b0;
    dmem_rvalid = 1'b0;
    dmem_rdata = '0;
    drive_idle();
    tick();
    tick();
    n_vec++;
    if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb} !== '0) begin
      n_bad++;
      $display("FAIL reset_dmem: got req=%b we=%b addr=%h wdata=%h strb=%h want all 0",
               dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb);
    end
    n_vec++;
    if ({mem_rd_data, mem_rd_addr, mem_rd_ena, mem_pc_o, mem_err, mem_stall_req} !== '0) begin
      n_bad++;
      $display("FAIL reset_mem: got data=%h addr=%0d ena=%b pc=%h err=%b stall=%b want all 0",
               mem_rd_data, mem_rd_addr, mem_rd_ena, mem_pc_o, mem_err, mem_stall_req);
    end
    rst = 1'b0;
  endtask

  task automatic test_alu_pass();
    res_t e;
    logic [3:0] ops [4] = '{4'd0, 4'd12, 4'd0, 4'd15};
    logic [63:0] vals [4] = '{64'h1234, 64'hDEAD_BEEF_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
    for (int i = 0; i < 4; i++) begin
      ex_valid = 1'b1;
      ex_mem_op = ops[i];
      ex_alu_res = vals[i];
      ex_rd_addr = (i == 0) ? 5'd5 : 5'(i * 7);
      ex_rd_ena = (i != 2);
      ex_pc_i = 64'h8000_0000 + 64'(4 * i);
      e.data = ex_alu_res;
      e.chk_data = 1'b1;
      e.addr = ex_rd_addr;
      e.ena = ex_rd_ena;
      e.pc = ex_pc_i;
      #1;
      n_vec++;
      if (mem_stall_req !== 1'b0) begin
        n_bad++;
        $display("FAIL alu_stall: got %b want 0", mem_stall_req);
      end
      sb.push_back(e);
      tick();
    end
    drive_idle();
    tick();
    n_vec++;
    if (mem_pc_o !== '0 || mem_rd_ena !== 1'b0) begin
      n_bad++;
      $display("FAIL alu_bubble: got pc=%h ena=%b want pc=0 ena=0", mem_pc_o, mem_rd_ena);
    end
  endtask

  task automatic test_lb_sign();
    int rq, st;
    bit er, we;
    logic [63:0] ca, cw;
    logic [7:0] cs;
    do_mem(4'd1, 64'h8000_1003, '0, 64'h0000_0000_80FF_0000, 64'hFFFF_FFFF_FFFF_FF80,
           0, 1, 5'd9, 64'h8000_0100, 1'b1, 1'b0, rq, st, er, ca, we, cs, cw);
    n_vec++;
    if (ca !== 64'h8000_1000 || we !== 1'b0) begin
      n_bad++;
      $display("FAIL lb_bus: got addr=%h we=%b want addr=0000000080001000 we=0", ca, we);
    end
    do_mem(4'd5, 64'h8000_1003, '0, 64'h0000_0000_80FF_0000, 64'h0000_0000_0000_0080,
           1, 0, 5'd10, 64'h8000_0104, 1'b1, 1'b1, rq, st, er, ca, we, cs, cw);
  endtask

  task automatic test_store_sh();
    int rq, st;
    bit er, we;
    logic [63:0] ca, cw;
    logic [7:0] cs;
    do_mem(4'd9, 64'h0000_2006, 64'h0000_0000_0000_ABCD, '0, '0,
           0, 1, 5'd3, 64'h8000_0200, 1'b1, 1'b0, rq, st, er, ca, we, cs, cw);
    n_vec++;
    if (cs !== 8'hC0 || cw !== 64'hABCD_0000_0000_0000 || we !== 1'b1 || ca !== 64'h2000) begin
      n_bad++;
      $display("FAIL sh_bus: got strb=%h wdata=%h we=%b addr=%h want strb=c0 wdata=abcd000000000000 we=1 addr=2000",
               cs, cw, we, ca);
    end
  endtask

  task automatic test_random_ops();
    int rq, st;
    bit er, we;
    logic [63:0] ca, cw, addr, rdata, sdata;
    logic [7:0] cs;
    logic [3:0] op;
    logic [2:0] off;
    for (int i = 0; i < 10; i++) begin
      op = (i < 6) ? 4'($urandom_range(1, 7)) : 4'($urandom_range(8, 11));
      off = 3'($urandom_range(0, 7));
      // keep offsets naturally aligned so both builds behave alike
      off = off & ~3'(op_bytes(op) - 1);
      addr = {$urandom, $urandom};
      addr[2:0] = off;
      rdata = {$urandom, $urandom};
      sdata = {$urandom, $urandom};
      do_mem(op, addr, sdata, rdata, exp_load(op, rdata, off), $urandom_range(0, 3), $urandom_range(0, 3),
             5'($urandom_range(1, 31)), 64'h9000_0000 + 64'(i * 4), 1'b1, 1'b0, rq, st, er, ca, we, cs, cw);
      n_vec++;
      if (ca !== {addr[63:3], 3'b000} || we !== (op >= 4'd8)) begin
        n_bad++;
        $display("FAIL rand_bus_addr op=%0d: got addr=%h we=%b want addr=%h we=%b",
                 op, ca, we, {addr[63:3], 3'b000}, (op >= 4'd8));
      end
      if (op >= 4'd8) begin
        n_vec++;
        if (cs !== exp_strb(op, off) || cw !== exp_wdata(op, sdata, off)) begin
          n_bad++;
          $display("FAIL rand_store op=%0d off=%0d: got strb=%h wdata=%h want strb=%h wdata=%h",
                   op, off, cs, cw, exp_strb(op, off), exp_wdata(op, sdata, off));
        end
      end
    end
  endtask

  task automatic test_delayed_handshake();
    int rq, st;
    bit er, we;
    logic [63:0] ca, cw;
    logic [7:0] cs;
    do_mem(4'd4, 64'h0000_3000, '0, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF,
           3, 2, 5'd17, 64'h8000_0300, 1'b1, 1'b0, rq, st, er, ca, we, cs, cw);
    n_vec++;
    if (rq != 4 || st != 6) begin
      n_bad++;
      $display("FAIL delayed_cycles: got req=%0d stall=%0d want req=4 stall=6", rq, st);
    end
  endtask

  task automatic test_timeout();
    int rq, st;
    bit er, we;
    logic [63:0] ca, cw;
    logic [7:0] cs;
    do_mem(4'd3, 64'h0000_4000, '0, '0, '0, 100000, 0, 5'd4, 64'h8000_0400,
           1'b0, 1'b0, rq, st, er, ca, we, cs, cw);
    n_vec++;
    if (!er || rq != TMO) begin
      n_bad++;
      $display("FAIL timeout_err: got err=%b req_cycles=%0d want err=1 req_cycles=%0d", er, rq, TMO);
    end
    n_vec++;
    if (mem_rd_ena !== 1'b0 || mem_pc_o !== '0 || mem_stall_req !== 1'b0 || dmem_req !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout_bubble: got ena=%b pc=%h stall=%b req=%b want all 0",
               mem_rd_ena, mem_pc_o, mem_stall_req, dmem_req);
    end
    tick();
    n_vec++;
    if (mem_err !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout_pulse: got err=%b want 0 one cycle later", mem_err);
    end
  endtask

  task automatic test_reset_mid();
    ex_valid = 1'b1;
    ex_mem_op = 4'd4;
    ex_alu_res = 64'h5000;
    ex_rd_addr = 5'd8;
    ex_rd_ena = 1'b1;
    ex_pc_i = 64'h8000_0500;
    tick();
    drive_idle();
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt = 1'b0;
    n_vec++;
    if (dmem_req !== 1'b0 || mem_stall_req !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_wait: got req=%b stall=%b want req=0 stall=1", dmem_req, mem_stall_req);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_vec++;
    if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb, mem_rd_data, mem_rd_addr,
         mem_rd_ena, mem_pc_o, mem_err, mem_stall_req} !== '0) begin
      n_bad++;
      $display("FAIL mid_reset: got req=%b pc=%h ena=%b err=%b stall=%b want all 0",
               dmem_req, mem_pc_o, mem_rd_ena, mem_err, mem_stall_req);
    end
    dmem_rvalid = 1'b1;
    dmem_rdata = 64'hFFFF_0000_FFFF_0000;
    tick();
    dmem_rvalid = 1'b0;
    n_vec++;
    if (mem_rd_ena !== 1'b0 || mem_pc_o !== '0 || mem_stall_req !== 1'b0 || mem_rd_data !== '0) begin
      n_bad++;
      $display("FAIL late_rvalid: got ena=%b pc=%h stall=%b data=%h want all 0",
               mem_rd_ena, mem_pc_o, mem_stall_req, mem_rd_data);
    end
  endtask

  task automatic test_idle_hold();
    sb_on = 1'b0;
    ex_valid = 1'b1;
    ex_mem_op = 4'd0;
    ex_alu_res = 64'hAAAA;
    ex_rd_addr = 5'd1;
    ex_rd_ena = 1'b1;
    ex_pc_i = 64'h8000_0600;
    tick();
    stall_ctrl = 5'b01000;
    ex_alu_res = 64'hBBBB;
    ex_pc_i = 64'h8000_0604;
    tick();
    n_vec++;
    if (mem_rd_data !== 64'hAAAA || mem_pc_o !== 64'h8000_0600) begin
      n_bad++;
      $display("FAIL idle_hold: got data=%h pc=%h want data=aaaa pc=80000600", mem_rd_data, mem_pc_o);
    end
    stall_ctrl = 5'b00000;
    tick();
    n_vec++;
    if (mem_rd_data !== 64'hBBBB || mem_pc_o !== 64'h8000_0604) begin
      n_bad++;
      $display("FAIL idle_release: got data=%h pc=%h want data=bbbb pc=80000604", mem_rd_data, mem_pc_o);
    end
    drive_idle();
    tick();
    sb_on = 1'b1;
  endtask

  task automatic test_misalign();
`ifdef MEM_MISALIGN_TRAP_EN
    ex_valid = 1'b1;
    ex_mem_op = 4'd3;
    ex_alu_res = 64'h6002;
    ex_rd_addr = 5'd6;
    ex_rd_ena = 1'b1;
    ex_pc_i = 64'h8000_0700;
    #1;
    n_vec++;
    if (mem_stall_req !== 1'b0) begin
      n_bad++;
      $display("FAIL trap_stall: got %b want 0", mem_stall_req);
    end
    tick();
    drive_idle();
    n_vec++;
    if (dmem_req !== 1'b0 || mem_err !== 1'b1 || mem_rd_ena !== 1'b0 || mem_pc_o !== '0) begin
      n_bad++;
      $display("FAIL trap_bubble: got req=%b err=%b ena=%b pc=%h want req=0 err=1 ena=0 pc=0",
               dmem_req, mem_err, mem_rd_ena, mem_pc_o);
    end
    tick();
    n_vec++;
    if (mem_err !== 1'b0 || dmem_req !== 1'b0) begin
      n_bad++;
      $display("FAIL trap_pulse: got err=%b req=%b want 0 0", mem_err, dmem_req);
    end
`else
    int rq, st;
    bit er, we;
    logic [63:0] ca, cw;
    logic [7:0] cs;
    do_mem(4'd7, 64'h6006, '0, 64'h1122_3344_5566_7788, 64'h0000_0000_0000_1122,
           0, 0, 5'd6, 64'h8000_0700, 1'b1, 1'b0, rq, st, er, ca, we, cs, cw);
    do_mem(4'd11, 64'h6005, 64'h0102_0304_0506_0708, '0, '0,
           0, 1, 5'd7, 64'h8000_0704, 1'b1, 1'b0, rq, st, er, ca, we, cs, cw);
    n_vec++;
    if (cs !== 8'hE0 || cw !== 64'h0607_0800_0000_0000 || ca !== 64'h6000) begin
      n_bad++;
      $display("FAIL misalign_drop: got strb=%h wdata=%h addr=%h want strb=e0 wdata=0607080000000000 addr=6000",
               cs, cw, ca);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_alu_pass();
    test_lb_sign();
    test_store_sh();
    test_delayed_handshake();
    test_random_ops();
    test_idle_hold();
    test_misalign();
    test_timeout();
    test_reset_mid();
    n_vec++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL sb_drain: %0d results never produced, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
